// File: rtl/gate_sequence_accumulator_pkg.sv
// Shared types and constants for the gate sequence accumulator.
//   WIDTH/FRAC : Q4.32 signed fixed-point word (sign, 4 integer, 32 fraction bits)
//   cword_t    : one fixed-point word
//   cmatrix_t  : 2x2 complex matrix, indexed [row][col][0=re,1=im]
//   IDENTITY   : 2x2 complex identity, ZERO : all-zero matrix
//   state_t    : FSM state encoding used by the accumulator
package gate_sequence_accumulator_pkg;

  localparam int WIDTH = 37;
  localparam int FRAC  = 32;

  typedef logic signed [WIDTH-1:0] cword_t;
  typedef cword_t cmatrix_t [0:1][0:1][0:1];

  localparam cword_t ONE = cword_t'(64'sd1 <<< FRAC);

  localparam cmatrix_t IDENTITY = '{'{'{ONE, '0}, '{'0, '0}},
                                    '{'{'0, '0}, '{ONE, '0}}};
  localparam cmatrix_t ZERO     = '{'{'{'0, '0}, '{'0, '0}},
                                    '{'{'0, '0}, '{'0, '0}}};

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ACCEPT = 3'd1;
  localparam state_t ST_ISSUE  = 3'd2;
  localparam state_t ST_WAIT   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/gate_sequence_accumulator_if.sv
// Bundle of the gate stream, multiplier handshake and unitary output.
//   slave  : accumulator view (consumes gates and multiplier results,
//            drives operands, start pulse, unitary and status)
//   master : environment view (gate source, multiplier, back end)
interface gate_sequence_accumulator_if #(
  parameter int CNT_W = 16
);
  import gate_sequence_accumulator_pkg::*;

  cmatrix_t           gate_in;
  logic               gate_valid;
  logic               gate_last;
  logic               gate_ready;
  cmatrix_t           mul_mtx_a;
  cmatrix_t           mul_mtx_b;
  logic               mul_ready;
  cmatrix_t           mul_mtx_r;
  logic               mul_available;
  cmatrix_t           unitary;
  logic               unitary_valid;
  logic               unitary_ack;
  logic [CNT_W-1:0]   gate_count;
  logic               error;

  modport slave (
    input  gate_in, gate_valid, gate_last, mul_mtx_r, mul_available, unitary_ack,
    output gate_ready, mul_mtx_a, mul_mtx_b, mul_ready, unitary, unitary_valid,
           gate_count, error
  );

  modport master (
    output gate_in, gate_valid, gate_last, mul_mtx_r, mul_available, unitary_ack,
    input  gate_ready, mul_mtx_a, mul_mtx_b, mul_ready, unitary, unitary_valid,
           gate_count, error
  );
endinterface

// File: rtl/gate_sequence_accumulator.sv
// Initiator side of the complex matrix multiplier handshake. Folds a stream
// of 2x2 complex gates into U = Gn*...*G2*G1 and hands U to the back end.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   bus    : slave modport carrying gate stream, multiplier operands/result,
//            unitary output, gate_count and error
//
// state  | meaning
// IDLE   | waiting for first gate of a sequence (loaded directly into acc)
// ACCEPT | waiting for next gate to multiply in
// ISSUE  | one-cycle start pulse to the multiplier
// WAIT   | waiting for multiplier result or timeout
// DONE   | unitary presented, held until ack
module gate_sequence_accumulator
  import gate_sequence_accumulator_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  gate_sequence_accumulator_if.slave bus
);

  localparam int              TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  cmatrix_t           acc_q, acc_d;
  cmatrix_t           gate_q, gate_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;

  logic gate_ready;
  logic gate_xfer;
  logic wait_first;

  assign gate_ready = (state_q == ST_IDLE) || (state_q == ST_ACCEPT);
  assign gate_xfer  = bus.gate_valid && gate_ready;
  // The timer still holds its load value only in the first WAIT cycle, where
  // a stale available level from the previous operation must be ignored.
  assign wait_first = (tmr_q == TMR_LOAD);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    gate_d  = gate_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (gate_xfer) begin
          acc_d   = bus.gate_in;
          cnt_d   = CNT_W'(1);
          err_d   = 1'b0;
          state_d = bus.gate_last ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (gate_xfer) begin
          gate_d  = bus.gate_in;
          last_d  = bus.gate_last;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_d   = TMR_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!wait_first && bus.mul_available) begin
          acc_d   = bus.mul_mtx_r;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          state_d = last_q ? ST_DONE : ST_ACCEPT;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.unitary_ack) begin
          acc_d   = IDENTITY;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= IDENTITY;
      gate_q  <= ZERO;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      gate_q  <= gate_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.gate_ready    = gate_ready;
  assign bus.mul_mtx_a     = gate_q;
  assign bus.mul_mtx_b     = acc_q;
  assign bus.mul_ready     = (state_q == ST_ISSUE);
  assign bus.unitary       = acc_q;
  assign bus.unitary_valid = (state_q == ST_DONE);
  assign bus.gate_count    = cnt_q;
  assign bus.error         = err_q;

endmodule
